// File: rtl/rmii_rx_frame_ctrl.sv
// Frame-level receive controller behind the rmii_v1 dibit-to-byte converter.
// Strips preamble/SFD, emits bytes with tlast/tuser, and counts good and bad frames.
module rmii_rx_frame_ctrl #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_en,
    input  logic             crs_dv,
    input  logic [7:0]       s_tdata,
    input  logic             s_tvalid,
    output logic [7:0]       m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast,
    output logic             m_tuser,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_err,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PRE  = 2'd1;
    localparam logic [1:0] PAY  = 2'd2;
    localparam logic [1:0] DROP = 2'd3;

    localparam logic [11:0] MIN_L    = 12'(MIN_LEN);
    localparam logic [11:0] MAX_L    = 12'(MAX_LEN);
    localparam logic [7:0]  PREAMBLE = 8'h55;
    localparam logic [7:0]  SFD      = 8'hD5;

    logic [1:0]  state;
    logic        crs_q;
    logic [7:0]  hold;
    logic        hold_full;
    logic [11:0] len_cnt;
    logic        seen_pre;
    logic        eoc;
    logic        inc_ok;
    logic        inc_err;

    // A byte arriving with crs_dv already low still belongs to the frame.
    assign eoc  = !crs_dv && !s_tvalid;
    assign busy = (state != IDLE);

    // Frame-outcome decode; at most one of the two strobes fires per cycle.
    always_comb begin
        // NOTE: defaults first so no path leaves a strobe unassigned (no latch).
        inc_ok  = 1'b0;
        inc_err = 1'b0;
        case (state)
            PRE: begin
                if (s_tvalid && s_tdata != PREAMBLE && !(s_tdata == SFD && seen_pre))
                    inc_err = 1'b1;
            end
            PAY: begin
                if (s_tvalid) begin
                    if (len_cnt == MAX_L)
                        inc_err = 1'b1;
                end else if (eoc) begin
                    if (hold_full && len_cnt >= MIN_L)
                        inc_ok = 1'b1;
                    else
                        inc_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            crs_q     <= 1'b1;
            hold      <= 8'h00;
            hold_full <= 1'b0;
            len_cnt   <= 12'd0;
            seen_pre  <= 1'b0;
            m_tdata   <= 8'h00;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            m_tuser   <= 1'b0;
        end else begin
            crs_q    <= crs_dv;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
            case (state)
                IDLE: begin
                    if (crs_dv && !crs_q && rx_en) begin
                        state    <= PRE;
                        seen_pre <= 1'b0;
                    end
                end
                PRE: begin
                    if (s_tvalid) begin
                        if (s_tdata == PREAMBLE) begin
                            seen_pre <= 1'b1;
                        end else if (s_tdata == SFD && seen_pre) begin
                            state     <= PAY;
                            len_cnt   <= 12'd0;
                            hold_full <= 1'b0;
                        end else begin
                            state <= DROP;
                        end
                    end else if (eoc) begin
                        state <= IDLE;
                    end
                end
                PAY: begin
                    if (s_tvalid) begin
                        if (len_cnt == MAX_L) begin
                            // Oversize: close the frame on the held byte and drop the rest.
                            m_tdata   <= hold;
                            m_tvalid  <= 1'b1;
                            m_tlast   <= 1'b1;
                            m_tuser   <= 1'b1;
                            hold_full <= 1'b0;
                            state     <= DROP;
                        end else begin
                            if (hold_full) begin
                                m_tdata  <= hold;
                                m_tvalid <= 1'b1;
                            end
                            hold      <= s_tdata;
                            hold_full <= 1'b1;
                            len_cnt   <= len_cnt + 12'd1;
                        end
                    end else if (eoc) begin
                        if (hold_full) begin
                            m_tdata  <= hold;
                            m_tvalid <= 1'b1;
                            m_tlast  <= 1'b1;
                            m_tuser  <= (len_cnt < MIN_L);
                        end
                        hold_full <= 1'b0;
                        state     <= IDLE;
                    end
                end
                DROP: begin
                    if (eoc)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating frame counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frames_ok  <= '0;
            frames_err <= '0;
        end else begin
            if (inc_ok && frames_ok != {CNT_W{1'b1}})
                frames_ok <= frames_ok + 1'b1;
            if (inc_err && frames_err != {CNT_W{1'b1}})
                frames_err <= frames_err + 1'b1;
        end
    end

endmodule

// File: tb/tb_rmii_rx_frame_ctrl.sv
// Randomized self-checking bench for rmii_rx_frame_ctrl against a frame-level model.
// A second instance with 2-bit counters checks counter saturation on the same stimulus.
module tb_rmii_rx_frame_ctrl;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_en = 1'b0;
    logic        crs_dv = 1'b0;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tuser;
    logic [15:0] frames_ok;
    logic [15:0] frames_err;
    logic        busy;

    logic [7:0]  m2_tdata;
    logic        m2_tvalid;
    logic        m2_tlast;
    logic        m2_tuser;
    logic [1:0]  frames_ok2;
    logic [1:0]  frames_err2;
    logic        busy2;

    int      vectors = 0;
    int      miscompares = 0;
    int      exp_ok = 0;
    int      exp_err = 0;
    beat_t   exp_q[$];
    beat_t   mon_b;
    byte_q_t fr;

    rmii_rx_frame_ctrl #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rx_en(rx_en), .crs_dv(crs_dv),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .frames_ok(frames_ok), .frames_err(frames_err), .busy(busy)
    );

    rmii_rx_frame_ctrl #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .rx_en(rx_en), .crs_dv(crs_dv),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .m_tdata(m2_tdata), .m_tvalid(m2_tvalid), .m_tlast(m2_tlast), .m_tuser(m2_tuser),
        .frames_ok(frames_ok2), .frames_err(frames_err2), .busy(busy2)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // Output monitor: every beat must match the next expected beat, in order.
    always @(negedge clk) begin
        if (rst) begin
            if (m_tvalid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(m_tdata), 32'hFFFF_FFFF);
                end else begin
                    mon_b = exp_q.pop_front();
                    check("m_tdata", 32'(m_tdata), 32'(mon_b.data));
                    check("m_tlast", 32'(m_tlast), 32'(mon_b.last));
                    check("m_tuser", 32'(m_tuser), 32'(mon_b.user));
                end
            end else begin
                check("flags_without_valid", 32'({m_tlast, m_tuser}), 32'd0);
            end
        end
    end

    // Frame-level reference: find the SFD, then decide the outcome from the payload length.
    task automatic model_frame(input byte_q_t b);
        int n = b.size();
        int k = 0;
        int plen;
        int nout;
        bit bad;
        while (k < n && b[k] == 8'h55) k++;
        if (k == n) return;
        if (b[k] != 8'hD5 || k == 0) begin
            exp_err++;
            return;
        end
        plen = n - k - 1;
        if (plen == 0) begin
            exp_err++;
            return;
        end
        nout = (plen > MAX_LEN) ? MAX_LEN : plen;
        bad  = (plen > MAX_LEN) || (plen < MIN_LEN);
        for (int i = 0; i < nout; i++)
            exp_q.push_back('{data: b[k+1+i], last: (i == nout - 1), user: (i == nout - 1) && bad});
        if (bad) exp_err++;
        else     exp_ok++;
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_frames_ok"}, 32'(frames_ok), exp_ok);
        check({tag, "_frames_err"}, 32'(frames_err), exp_err);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_drained"}, exp_q.size(), 32'd0);
        check({tag, "_sat_ok"}, 32'(frames_ok2), sat3(exp_ok));
        check({tag, "_sat_err"}, 32'(frames_err2), sat3(exp_err));
    endtask

    task automatic build(input int npre, input bit sfd, input int len, input bit incr);
        fr.delete();
        repeat (npre) fr.push_back(8'h55);
        if (sfd) fr.push_back(8'hD5);
        for (int i = 0; i < len; i++)
            fr.push_back(incr ? 8'(i) : 8'($urandom_range(0, 255)));
    endtask

    task automatic send_frame(input string tag, input bit en, input byte_q_t b, input bit tail_low);
        int n = b.size();
        if (en) model_frame(b);
        rx_en    = en;
        crs_dv   = 1'b0;
        s_tvalid = 1'b0;
        tick();
        crs_dv = 1'b1;
        tick();
        rx_en = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 3)) tick();
        check({tag, "_busy_in_frame"}, 32'(busy), 32'(en));
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            s_tdata  = b[i];
            s_tvalid = 1'b1;
            if (tail_low && i == n - 1) crs_dv = 1'b0;
            tick();
            s_tvalid = 1'b0;
            if ($urandom_range(0, 7) == 0) rx_en = ~rx_en;
        end
        if (!tail_low) repeat ($urandom_range(0, 2)) tick();
        crs_dv = 1'b0;
        repeat (6) tick();
        end_checks(tag);
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #5 rst = 1'b0;
        repeat (3) tick();
        check("reset_m_tvalid", 32'(m_tvalid), 32'd0);
        check("reset_flags", 32'({m_tlast, m_tuser}), 32'd0);
        check("reset_m_tdata", 32'(m_tdata), 32'd0);
        check("reset_counters", 32'({frames_ok, frames_err}), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        repeat (3) tick();

        build(7, 1, 64, 1);    send_frame("good_min", 1, fr, 0);
        build(7, 1, 10, 1);    send_frame("runt", 1, fr, 0);
        build(7, 1, 1600, 1);  send_frame("oversize", 1, fr, 0);
        build(7, 1, 100, 0);   send_frame("after_oversize", 1, fr, 0);
        build(2, 0, 0, 0);
        fr.push_back(8'hAA);
        for (int i = 0; i < 20; i++) fr.push_back(8'($urandom_range(0, 255)));
        send_frame("bad_preamble", 1, fr, 0);
        build(0, 1, 20, 0);    send_frame("sfd_first", 1, fr, 0);
        build(7, 1, 100, 0);   send_frame("rx_disabled", 0, fr, 0);
        build(7, 1, 70, 1);    send_frame("tail_low", 1, fr, 1);
        build(7, 1, 0, 0);     send_frame("zero_len", 1, fr, 0);
        build(3, 0, 0, 0);     send_frame("pre_only", 1, fr, 0);
        build(7, 1, MAX_LEN, 0);     send_frame("exact_max", 1, fr, 0);
        build(7, 1, MIN_LEN - 1, 0); send_frame("min_minus_1", 1, fr, 1);

        // Reset in the middle of a frame, released while the carrier is still up.
        build(7, 1, 100, 0);
        for (int i = 0; i < 21; i++) exp_q.push_back('{data: fr[8+i], last: 1'b0, user: 1'b0});
        rx_en  = 1'b1;
        crs_dv = 1'b0;
        tick();
        crs_dv = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 30; i++) begin
            s_tdata  = fr[i];
            s_tvalid = 1'b1;
            tick();
            s_tvalid = 1'b0;
            tick();
        end
        check("pre_reset_drained", exp_q.size(), 32'd0);
        rst = 1'b0;
        #1;
        check("midreset_m_tvalid", 32'(m_tvalid), 32'd0);
        check("midreset_counters", 32'({frames_ok, frames_err}), 32'd0);
        check("midreset_sat_counters", 32'({frames_ok2, frames_err2}), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        exp_ok  = 0;
        exp_err = 0;
        exp_q.delete();
        repeat (3) tick();
        rst = 1'b1;
        for (int i = 30; i < fr.size(); i++) begin
            s_tdata  = fr[i];
            s_tvalid = 1'b1;
            tick();
            s_tvalid = 1'b0;
            tick();
        end
        crs_dv = 1'b0;
        repeat (6) tick();
        end_checks("reset_remainder");
        build(7, 1, 80, 0);    send_frame("post_reset_good", 1, fr, 0);
        check("post_reset_one_ok", 32'(frames_ok), 32'd1);

        for (int f = 0; f < 4; f++) begin
            build($urandom_range(1, 7), 1, $urandom_range(MIN_LEN, 120), 0);
            send_frame("good_burst", 1, fr, 1'($urandom_range(0, 1)));
        end
        check("saturated_ok", 32'(frames_ok2), 32'd3);

        for (int f = 0; f < 30; f++) begin
            int   kind;
            int   len;
            logic [7:0] b;
            kind = $urandom_range(0, 9);
            len  = $urandom_range(0, 150);
            build($urandom_range(1, 7), 0, 0, 0);
            case (kind)
                0: begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'h55 || b == 8'hD5) b = 8'h12;
                    fr.push_back(b);
                end
                1: len = 0;
                2: begin
                    fr.delete();
                    fr.push_back(8'hD5);
                end
                default: fr.push_back(8'hD5);
            endcase
            for (int i = 0; i < len; i++) fr.push_back(8'($urandom_range(0, 255)));
            send_frame("random", ($urandom_range(0, 5) != 0), fr, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rmii_rx_frame_ctrl.md
Name: rmii_rx_frame_ctrl

Overview:
- Frame-level receive controller placed directly after the rmii_v1 dibit-to-byte converter.
- Uses the converter's byte stream and the raw CRS_DV envelope to delimit Ethernet frames and to strip the preamble and SFD.
- Emits an AXI-Stream-style byte stream with tlast and an error flag, and flags runt and oversize frames.
- Keeps saturating good-frame and error-frame counters for the feed-handler status logic.

Parameters:
- MIN_LEN, 64: minimum legal frame length in bytes, DA through FCS inclusive.
- MAX_LEN, 1518: maximum legal frame length in bytes, DA through FCS inclusive.
- CNT_W, 16: width of each frame counter.

Ports:
- clk, in, 1: 50 MHz RMII reference clock.
- rst, in, 1: asynchronous reset, active-low.
- rx_en, in, 1: receive enable; sampled only in IDLE.
- crs_dv, in, 1: RMII carrier sense / data valid.
- s_tdata, in, 8: byte from rmii_v1.
- s_tvalid, in, 1: s_tdata valid this cycle.
- m_tdata, out, 8: payload byte.
- m_tvalid, out, 1: m_tdata valid; no backpressure.
- m_tlast, out, 1: last byte of the frame.
- m_tuser, out, 1: frame error; valid only with m_tlast.
- frames_ok, out, CNT_W: count of good frames.
- frames_err, out, CNT_W: count of runt, oversize and bad-preamble frames.
- busy, out, 1: state is not IDLE.

Behaviour:
- Reset (rst=0):
  - State goes to IDLE.
  - All outputs go to 0 and both counters clear.
  - The hold register is emptied, len_cnt is cleared and crs_q is set to 1.
- crs_q is crs_dv delayed by one cycle.
  - Because crs_q resets to 1, releasing reset in the middle of a frame never starts a frame.
- End-of-carrier (eoc) is the condition crs_dv==0 && s_tvalid==0 in the same cycle.
  - A byte that arrives with crs_dv low is still part of the current frame.
- IDLE:
  - Go to PRE when crs_dv==1 && crs_q==0 && rx_en==1.
  - If a crs_dv rising edge occurs while rx_en==0, stay in IDLE and ignore the frame.
- PRE:
  - s_tvalid with byte 0x55: stay in PRE.
  - s_tvalid with byte 0xD5 after at least one 0x55: go to PAY and set len_cnt=0.
  - Any other byte, or 0xD5 as the first byte: go to DROP and increment frames_err. Nothing is emitted.
  - eoc while in PRE: return to IDLE silently, with no counter change.
- PAY:
  - Hold register: each s_tvalid byte is written into hold, and len_cnt increments (12 bits, no wrap below MAX_LEN+1).
  - Emission when hold is already full and a new byte arrives: emit the old hold byte with m_tvalid=1 and m_tlast=0.
  - Emission on eoc:
    - If hold is full, emit the hold byte with m_tlast=1. Set m_tuser=1 if len_cnt<MIN_LEN.
    - Increment frames_ok or frames_err accordingly, then go to IDLE.
    - If hold is empty (zero-byte frame), emit nothing, increment frames_err and go to IDLE.
  - Oversize: when a byte arrives and len_cnt==MAX_LEN:
    - Emit the hold byte with m_tlast=1 and m_tuser=1.
    - Discard the new byte, increment frames_err and go to DROP.
- DROP:
  - Ignore all bytes.
  - Go to IDLE on eoc.
- Latency: a payload byte appears on m_tdata one s_tvalid later, or one cycle after eoc for the final byte. All outputs are registered.
- m_tvalid is a single-cycle pulse per byte. m_tlast and m_tuser are 0 whenever m_tvalid is 0.
- Counters saturate at 2^CNT_W-1.
- A change of rx_en mid-frame has no effect; the current frame completes normally.
- Both counters can never increment in the same cycle.

Test Plan:
- Good minimum frame: crs_dv rises; 7x 0x55, then 0xD5; then 64 bytes 0x00..0x3F; then eoc.
  -> 64 m_tvalid pulses with data 0x00..0x3F.
  -> m_tlast only on 0x3F, with m_tuser=0.
  -> frames_ok=1, frames_err=0, busy back to 0.
- Runt: same preamble, then 10 bytes, then eoc.
  -> 10 bytes out; the last has m_tlast=1 and m_tuser=1.
  -> frames_err=1.
- Oversize: preamble, then 1600 bytes.
  -> Exactly 1518 bytes out; byte 1518 has m_tlast=1 and m_tuser=1.
  -> Remaining bytes dropped, frames_err=1.
  -> The next good frame is received intact.
- Bad preamble: 0x55, 0x55, 0xAA, then 20 bytes.
  -> No m_tvalid, frames_err=1, state returns to IDLE after eoc.
- Gating and reset:
  - rx_en=0 at the crs_dv rise of a 100-byte frame -> no output and counters unchanged.
  - Assert rst at byte 30 of a frame and release it while crs_dv is high -> outputs 0, counters 0, the remainder is ignored, and the next frame yields frames_ok=1.
- Tail byte with crs_dv low: the final payload byte arrives with crs_dv already low, then eoc on the next cycle.
  -> That byte is emitted with m_tlast=1.
  -> Counter saturation is checked by forcing CNT_W=2: 5 good frames -> frames_ok=3.
